// File: rtl/stream_mux_rr.sv
// stream_mux_rr: N_CH-input round-robin stream multiplexer with one registered
// output stage. Each input has its own valid/ready handshake, and the output
// reports which channel the held beat came from.
//
// Optional feature macro: STREAM_MUX_RR_PKT_LOCK_EN
//   When it is defined, a channel keeps the grant from its first beat until
//   the beat that carries in_last. When it is undefined, arbitration happens
//   on every beat and in_last is only passed through.
//
// Packet lock FSM (only with STREAM_MUX_RR_PKT_LOCK_EN):
//   state  | meaning
//   IDLE   | round-robin arbitration from ptr
//   LOCKED | grant pinned to lck_ch until its beat with in_last=1

module stream_mux_rr #(
  parameter int N_CH = 4,
  parameter int W    = 4,
  localparam int SEL_W = $clog2(N_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_CH-1:0]   in_valid,
  input  logic [N_CH*W-1:0] in_data,
  input  logic [N_CH-1:0]   in_last,
  output logic [N_CH-1:0]   in_ready,
  output logic              out_valid,
  output logic [W-1:0]      out_data,
  output logic [SEL_W-1:0]  out_sel,
  output logic              out_last,
  input  logic              out_ready
);

  function automatic logic [SEL_W-1:0] next_ch(input logic [SEL_W-1:0] ch);
    return (int'(ch) == N_CH - 1) ? '0 : ch + 1'b1;
  endfunction

  logic             load;
  logic             rr_vld;
  logic [SEL_W-1:0] rr_gnt;
  logic             gnt_vld;
  logic [SEL_W-1:0] gnt;
  logic             acc;
  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] ptr_nxt;

  assign load = !out_valid || out_ready;

  // Round-robin scan. The loop runs from the farthest offset down to ptr, so
  // the requester closest to ptr is the one that is kept.
  always_comb begin
    logic [SEL_W-1:0] idx;
    rr_vld = 1'b0;
    rr_gnt = '0;
    idx    = '0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      idx = SEL_W'((int'(ptr) + k) % N_CH);
      if (in_valid[idx]) begin
        rr_vld = 1'b1;
        rr_gnt = idx;
      end
    end
  end

`ifdef STREAM_MUX_RR_PKT_LOCK_EN
  typedef enum logic {IDLE, LOCKED} state_t;

  state_t           state, state_nxt;
  logic [SEL_W-1:0] lck_ch, lck_nxt;

  // Lock next-state logic. While LOCKED, the grant stays on lck_ch even if
  // that channel is idle.
  always_comb begin
    state_nxt = state;
    lck_nxt   = lck_ch;
    ptr_nxt   = ptr;
    gnt_vld   = rr_vld;
    gnt       = rr_gnt;
    if (state == LOCKED) begin
      gnt_vld = in_valid[lck_ch];
      gnt     = lck_ch;
    end
    acc = rst_n && load && gnt_vld;
    case (state)
      IDLE: begin
        if (acc) begin
          ptr_nxt = next_ch(gnt);
          if (!in_last[gnt]) begin
            state_nxt = LOCKED;
            lck_nxt   = gnt;
          end
        end
      end
      LOCKED: begin
        if (acc && in_last[gnt]) begin
          state_nxt = IDLE;
          ptr_nxt   = next_ch(lck_ch);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Lock state registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      lck_ch <= '0;
    end else begin
      state  <= state_nxt;
      lck_ch <= lck_nxt;
    end
  end
`else
  // Arbitration on every beat. The pointer moves past each channel it serves.
  always_comb begin
    gnt_vld = rr_vld;
    gnt     = rr_gnt;
    acc     = rst_n && load && gnt_vld;
    ptr_nxt = acc ? next_ch(gnt) : ptr;
  end
`endif

  // Ready is one-hot on the granted channel. It is gated by reset, so no beat
  // is accepted while reset is asserted.
  always_comb begin
    in_ready = '0;
    if (acc) in_ready[gnt] = 1'b1;
  end

  // Output stage and round-robin pointer. A beat held here when reset
  // arrives is dropped.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      out_last  <= 1'b0;
      ptr       <= '0;
    end else begin
      ptr <= ptr_nxt;
      if (load) begin
        out_valid <= gnt_vld;
        if (gnt_vld) begin
          out_data <= in_data[int'(gnt)*W +: W];
          out_sel  <= gnt;
          out_last <= in_last[gnt];
        end
      end
    end
  end

endmodule
